// File: rtl/f_cmp_pkg.sv
// Shared floating-point compare definitions: operand width, field sizes,
// the responder state encoding and NaN/zero classification helpers.
package f_cmp_pkg;

  // Shared config: operand width used by the sorter cluster.
  localparam int FLEN   = 64;
  localparam int EXP_W  = 11;
  localparam int MANT_W = 52;

  typedef enum logic [1:0] {
    IDLE,
    CLASSIFY,
    COMPARE,
    RESP
  } state_t;

  function automatic logic is_nan(input logic [FLEN-1:0] x);
    return (&x[FLEN-2 -: EXP_W]) && (|x[MANT_W-1:0]);
  endfunction

  // +0 and -0 both count as zero.
  function automatic logic is_zero(input logic [FLEN-1:0] x);
    return ~|x[FLEN-2:0];
  endfunction

endpackage

// File: rtl/f_le_seq_responder.sv
// Sequential floating-point a <= b responder: classifies NaN/zero/sign cases,
// then compares magnitudes CHUNK bits per cycle from the MSB with early exit.
module f_le_seq_responder #(
  parameter int FLEN  = f_cmp_pkg::FLEN,
  parameter int CHUNK = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [FLEN-1:0] req_a,
  input  logic [FLEN-1:0] req_b,
  output logic            rsp_valid,
  output logic            rsp_res,
  output logic            rsp_err
);
  import f_cmp_pkg::*;

  localparam int NUM_CHUNKS = FLEN / CHUNK;
  localparam int IDX_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;

  state_t                  state, state_nxt;
  logic [FLEN-1:0]         a_r, b_r;
  logic [IDX_W-1:0]        idx, idx_nxt;
  logic                    res_r, res_nxt;
  logic                    err_r, err_nxt;
  logic                    load;

  logic [NUM_CHUNKS-1:0][CHUNK-1:0] chunks_a, chunks_b;
  logic [CHUNK-1:0]        ca, cb;
  logic                    last_chunk;

  // Magnitudes with the sign forced to zero, split into chunks (MSB chunk on top).
  assign chunks_a   = {1'b0, a_r[FLEN-2:0]};
  assign chunks_b   = {1'b0, b_r[FLEN-2:0]};
  assign last_chunk = (idx == IDX_W'(NUM_CHUNKS - 1));

  always_comb begin
    ca = '0;
    cb = '0;
    for (int k = 0; k < NUM_CHUNKS; k++) begin
      if (idx == IDX_W'(k)) begin
        ca = chunks_a[NUM_CHUNKS-1-k];
        cb = chunks_b[NUM_CHUNKS-1-k];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    res_nxt   = res_r;
    err_nxt   = err_r;
    load      = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          load      = 1'b1;
          state_nxt = CLASSIFY;
        end
      end
      CLASSIFY: begin
        idx_nxt = '0;
        if (is_nan(a_r) || is_nan(b_r)) begin
          err_nxt   = 1'b1;
          res_nxt   = 1'b0;
          state_nxt = RESP;
        end else if (is_zero(a_r) && is_zero(b_r)) begin
          err_nxt   = 1'b0;
          res_nxt   = 1'b1;
          state_nxt = RESP;
        end else if (a_r[FLEN-1] != b_r[FLEN-1]) begin
          err_nxt   = 1'b0;
          res_nxt   = a_r[FLEN-1];
          state_nxt = RESP;
        end else begin
          state_nxt = COMPARE;
        end
      end
      COMPARE: begin
        // Same sign here: larger magnitude is the smaller value when negative.
        if (ca != cb) begin
          err_nxt   = 1'b0;
          res_nxt   = a_r[FLEN-1] ? (ca > cb) : (ca < cb);
          state_nxt = RESP;
        end else if (last_chunk) begin
          err_nxt   = 1'b0;
          res_nxt   = 1'b1;
          state_nxt = RESP;
        end else begin
          idx_nxt = idx + IDX_W'(1);
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Control state: reset returns to IDLE and clears the held response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
      res_r <= 1'b0;
      err_r <= 1'b0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      res_r <= res_nxt;
      err_r <= err_nxt;
    end
  end

  // Operand capture: only loaded on acceptance, no reset needed.
  always_ff @(posedge clk) begin
    if (load) begin
      a_r <= req_a;
      b_r <= req_b;
    end
  end

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign rsp_res   = res_r;
  assign rsp_err   = err_r;

endmodule
